// File: rtl/cpu_pkg.sv
// Shared CPU constants: I/O opcodes, interrupt FSM states and default widths.
package cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PC_W   = 16;

    localparam logic [4:0] OP_RFI = 5'b11010;
    localparam logic [4:0] OP_SFO = 5'b11011;
    localparam logic [4:0] OP_RFO = 5'b11100;
    localparam logic [4:0] OP_ION = 5'b11101;
    localparam logic [4:0] OP_IOF = 5'b11110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/io_intr_unit_in_buf.sv
// Input byte storage: single register by default, 2-entry FIFO when
// IO_INPUT_BUF_EN is defined.
module io_in_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] data,
    output logic              empty,
    output logic              full
);

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

`ifdef IO_INPUT_BUF_EN
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);
    assign data  = empty ? '0 : mem[rd_ptr];
`else
    logic [DATA_W-1:0] hold;
    logic              valid;

    // Push only happens when empty, so push and pop never collide here.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold  <= '0;
            valid <= 1'b0;
        end else if (do_push) begin
            hold  <= in_data;
            valid <= 1'b1;
        end else if (do_pop) begin
            hold  <= '0;
            valid <= 1'b0;
        end
    end

    assign empty = !valid;
    assign full  = valid;
    assign data  = hold;
`endif

endmodule

// File: rtl/io_intr_unit.sv
// Programmed I/O flags and interrupt entry sequencer.
// Optional 2-entry input FIFO selected by IO_INPUT_BUF_EN.
module io_intr_unit
    import cpu_pkg::*;
#(
    parameter int              DATA_W     = DEF_DATA_W,
    parameter int              PC_W       = DEF_PC_W,
    parameter logic [PC_W-1:0] INT_VECTOR = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rFI,
    input  logic              sFO,
    input  logic              rFO,
    input  logic              ION,
    input  logic              IOF,
    input  logic              instr_boundary,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] inpr,
    input  logic              cpu_out_we,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              irq_take,
    output logic [PC_W-1:0]   irq_pc
);

    irq_state_t        state;
    irq_state_t        state_next;
    logic              fgo_q;
    logic              ien_q;
    logic              irq_take_q;
    logic [DATA_W-1:0] outr_q;
    logic              buf_empty;
    logic              buf_full;
    logic              out_hs;
    logic              irq_cond;

    io_in_buf #(
        .DATA_W (DATA_W)
    ) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid && !buf_full),
        .pop     (rFI),
        .in_data (in_data),
        .data    (inpr),
        .empty   (buf_empty),
        .full    (buf_full)
    );

    assign out_hs   = !fgo_q && out_ready;
    assign irq_cond = ien_q && (!buf_empty || fgo_q);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (irq_cond) state_next = REQ;
            REQ: begin
                if (!irq_cond)
                    state_next = IDLE;
                else if (instr_boundary)
                    state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            irq_take_q <= 1'b0;
        end else begin
            state      <= state_next;
            irq_take_q <= (state_next == ACK);
        end
    end

    // Leaving ACK clears IEN even against a same-cycle ION.
    always_ff @(posedge clk) begin
        if (reset) begin
            fgo_q  <= 1'b1;
            ien_q  <= 1'b0;
            outr_q <= '0;
        end else begin
            if (sFO || out_hs)
                fgo_q <= 1'b1;
            else if (rFO)
                fgo_q <= 1'b0;
            if (cpu_out_we && fgo_q)
                outr_q <= cpu_out_data;
            if (state == ACK)
                ien_q <= 1'b0;
            else if (IOF)
                ien_q <= 1'b0;
            else if (ION)
                ien_q <= 1'b1;
        end
    end

    assign in_ready  = !buf_full;
    assign fgi       = !buf_empty;
    assign fgo       = fgo_q;
    assign out_valid = !fgo_q;
    assign out_data  = outr_q;
    assign ien       = ien_q;
    assign irq_take  = irq_take_q;
    assign irq_pc    = INT_VECTOR;

endmodule

// File: tb/tb_io_intr_unit.sv
// Randomized bench for io_intr_unit against a behavioural model.
// Honours IO_INPUT_BUF_EN for input storage depth.
module tb_io_intr_unit;

    localparam int DW = 8;
    localparam int PW = 16;
`ifdef IO_INPUT_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk;
    logic          reset;
    logic          rFI, sFO, rFO, ION, IOF;
    logic          instr_boundary;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] inpr;
    logic          cpu_out_we;
    logic [DW-1:0] cpu_out_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          fgi, fgo, ien;
    logic          irq_take;
    logic [PW-1:0] irq_pc;

    io_intr_unit #(
        .DATA_W     (DW),
        .PC_W       (PW),
        .INT_VECTOR (16'h0001)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rFI            (rFI),
        .sFO            (sFO),
        .rFO            (rFO),
        .ION            (ION),
        .IOF            (IOF),
        .instr_boundary (instr_boundary),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .inpr           (inpr),
        .cpu_out_we     (cpu_out_we),
        .cpu_out_data   (cpu_out_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .fgi            (fgi),
        .fgo            (fgo),
        .ien            (ien),
        .irq_take       (irq_take),
        .irq_pc         (irq_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: byte queue, flags and an interrupt "pending/taking" pair.
    logic [DW-1:0] byte_q [$];
    logic          m_fgo;
    logic          m_ien;
    logic [DW-1:0] m_outr;
    logic          m_pend;
    logic          m_take;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        byte_q.delete();
        m_fgo  = 1'b1;
        m_ien  = 1'b0;
        m_outr = '0;
        m_pend = 1'b0;
        m_take = 1'b0;
    endtask

    task automatic model_step();
        bit cond, cap, pop, hs;
        bit n_pend, n_take, n_ien, n_fgo;
        if (reset) begin
            model_reset();
            return;
        end
        cond = m_ien && (byte_q.size() > 0 || m_fgo);
        cap  = in_valid && (byte_q.size() < DEPTH);
        pop  = rFI && (byte_q.size() > 0);
        hs   = !m_fgo && out_ready;
        if (m_take) begin
            n_take = 0; n_pend = 0;
        end else if (m_pend) begin
            n_take = cond && instr_boundary;
            n_pend = cond && !instr_boundary;
        end else begin
            n_take = 0; n_pend = cond;
        end
        if (m_take)   n_ien = 0;
        else if (IOF) n_ien = 0;
        else if (ION) n_ien = 1;
        else          n_ien = m_ien;
        if (sFO || hs) n_fgo = 1;
        else if (rFO)  n_fgo = 0;
        else           n_fgo = m_fgo;
        if (cpu_out_we && m_fgo) m_outr = cpu_out_data;
        if (pop) void'(byte_q.pop_front());
        if (cap) byte_q.push_back(in_data);
        m_take = n_take;
        m_pend = n_pend;
        m_ien  = n_ien;
        m_fgo  = n_fgo;
    endtask

    task automatic compare_all();
        check("fgi", 32'(fgi), 32'(byte_q.size() > 0));
        check("inpr", 32'(inpr), byte_q.size() > 0 ? 32'(byte_q[0]) : 32'd0);
        check("in_ready", 32'(in_ready), 32'(byte_q.size() < DEPTH));
        check("fgo", 32'(fgo), 32'(m_fgo));
        check("out_valid", 32'(out_valid), 32'(!m_fgo));
        check("out_data", 32'(out_data), 32'(m_outr));
        check("ien", 32'(ien), 32'(m_ien));
        check("irq_take", 32'(irq_take), 32'(m_take));
        check("irq_pc", 32'(irq_pc), 32'h0001);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        reset          = 1'b0;
        rFI            = 1'b0;
        sFO            = 1'b0;
        rFO            = 1'b0;
        ION            = 1'b0;
        IOF            = 1'b0;
        instr_boundary = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        cpu_out_we     = 1'b0;
        cpu_out_data   = '0;
        out_ready      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // Reset state
        reset = 1'b1;
        cycle();
        check("rst_fgi", 32'(fgi), 32'd0);
        check("rst_fgo", 32'(fgo), 32'd1);
        check("rst_ien", 32'(ien), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inpr", 32'(inpr), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_irq_take", 32'(irq_take), 32'd0);

        // Input capture
        idle_inputs();
        in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        check("cap_fgi", 32'(fgi), 32'd1);
        check("cap_inpr", 32'(inpr), 32'hA5);
        check("cap_in_ready", 32'(in_ready), 32'(DEPTH > 1));
        idle_inputs();
        rFI = 1'b1;
        cycle();
        check("pop_fgi", 32'(fgi), 32'd0);
        cycle();
        check("pop_empty_fgi", 32'(fgi), 32'd0);

        // Same-cycle priorities
        idle_inputs();
        ION = 1'b1; IOF = 1'b1;
        cycle();
        check("ion_iof_ien", 32'(ien), 32'd0);
        idle_inputs();
        sFO = 1'b1; rFO = 1'b1;
        cycle();
        check("sfo_rfo_fgo", 32'(fgo), 32'd1);

        // Output handshake
        idle_inputs();
        cpu_out_we = 1'b1; cpu_out_data = 8'h3C;
        cycle();
        idle_inputs();
        rFO = 1'b1;
        cycle();
        check("out_pend_valid", 32'(out_valid), 32'd1);
        check("out_pend_data", 32'(out_data), 32'h3C);
        idle_inputs();
        cpu_out_we = 1'b1; cpu_out_data = 8'hFF;
        cycle();
        check("out_we_ignored", 32'(out_data), 32'h3C);
        idle_inputs();
        out_ready = 1'b1;
        cycle();
        check("out_done_fgo", 32'(fgo), 32'd1);
        check("out_done_valid", 32'(out_valid), 32'd0);

        // Interrupt entry
        idle_inputs();
        ION = 1'b1;
        cycle();
        check("int_ien_set", 32'(ien), 32'd1);
        idle_inputs();
        cycle();
        check("int_req_no_take", 32'(irq_take), 32'd0);
        instr_boundary = 1'b1;
        cycle();
        check("int_take", 32'(irq_take), 32'd1);
        check("int_pc", 32'(irq_pc), 32'h0001);
        instr_boundary = 1'b0;
        ION = 1'b1;
        cycle();
        check("int_take_once", 32'(irq_take), 32'd0);
        check("int_ien_clr", 32'(ien), 32'd0);

        // Reset while requesting
        idle_inputs();
        ION = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        reset = 1'b1; instr_boundary = 1'b1;
        cycle();
        check("rreq_take", 32'(irq_take), 32'd0);
        check("rreq_ien", 32'(ien), 32'd0);
        check("rreq_fgo", 32'(fgo), 32'd1);
        idle_inputs();
        instr_boundary = 1'b1;
        cycle();
        check("rreq_after_take", 32'(irq_take), 32'd0);

        // Input storage depth behaviour
        idle_inputs();
        in_valid = 1'b1; in_data = 8'h11;
        cycle();
        in_data = 8'h22;
        cycle();
`ifdef IO_INPUT_BUF_EN
        check("fifo_full", 32'(in_ready), 32'd0);
        check("fifo_head", 32'(inpr), 32'h11);
        idle_inputs();
        rFI = 1'b1;
        cycle();
        check("fifo_pop_head", 32'(inpr), 32'h22);
        in_valid = 1'b1; in_data = 8'h33;
        cycle();
        check("fifo_held_fgi", 32'(fgi), 32'd1);
        check("fifo_held_ready", 32'(in_ready), 32'd1);
        check("fifo_held_inpr", 32'(inpr), 32'h33);
`else
        check("reg_full", 32'(in_ready), 32'd0);
        check("reg_keep_first", 32'(inpr), 32'h11);
        idle_inputs();
        rFI = 1'b1;
        cycle();
        check("reg_pop_empty", 32'(fgi), 32'd0);
        in_valid = 1'b1; in_data = 8'h33;
        cycle();
        check("reg_pop_push", 32'(inpr), 32'h33);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            rFI            = ($urandom_range(0, 99) < 25);
            sFO            = ($urandom_range(0, 99) < 8);
            rFO            = ($urandom_range(0, 99) < 20);
            ION            = ($urandom_range(0, 99) < 15);
            IOF            = ($urandom_range(0, 99) < 5);
            instr_boundary = ($urandom_range(0, 99) < 35);
            in_valid       = ($urandom_range(0, 99) < 40);
            in_data        = DW'($urandom);
            cpu_out_we     = ($urandom_range(0, 99) < 30);
            cpu_out_data   = DW'($urandom);
            out_ready      = ($urandom_range(0, 99) < 30);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
